// File: rtl/csel_pipe_adder.sv
// -----------------------------------------------------------------------------
// csel_pipe_adder
//
// Pipelined carry-select adder/subtractor. The operands are split into NBLK
// blocks of BLK bits. Each block gets one pipeline stage. A stage forms two
// ripple sums, one with carry-in 0 and one with carry-in 1. It then picks one
// of them using the carry registered by the previous stage. Stage 0 uses the
// operation carry-in c0.
//
// Operand prep at accept:
//   B' = in_sub ? ~in_b : in_b
//   c0 = in_sub ? 1     : in_cin
//   {out_cout, out_sum} = A + B' + c0
//
// Stall control is global. advance = out_ready | ~out_valid. Every stage
// register, including its valid bit, updates only when advance is 1.
// Bubbles are not collapsed.
//
// Parameters:
//   WIDTH  operand / sum width in bits (default 64)
//   BLK    carry-select block width   (default 16, must divide WIDTH)
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   in_valid   operand set valid
//   in_ready   block can accept this cycle
//   in_a       operand A
//   in_b       operand B
//   in_cin     carry-in, ignored when in_sub=1
//   in_sub     1 = A - B, 0 = A + B + cin
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_sum    result
//   out_cout   carry out of MSB (for subtract, 1 = no borrow)
//   out_ovf    signed overflow, present only when CSEL_OVF_EN is defined
//
// Optional feature macro: CSEL_OVF_EN
//   Defined   : adds out_ovf = carry into MSB ^ carry out of MSB. It is
//               pipelined with the sum.
//   Undefined : out_ovf is absent and no extra logic is built.
// -----------------------------------------------------------------------------
module csel_pipe_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned BLK   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef CSEL_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned NBLK = WIDTH / BLK;
  // Operand forwarding registers exist only between stages. The array is kept
  // at least one entry deep so that NBLK=1 still elaborates.
  localparam int unsigned NOPR = (NBLK > 1) ? NBLK - 1 : 1;

  if (BLK == 0 || (WIDTH % BLK) != 0) begin : g_bad_param
    $error("csel_pipe_adder: WIDTH must be a non-zero multiple of BLK");
  end

  // Bit-serial ripple sum of one block. Returns {carry_out, sum}.
  function automatic logic [BLK:0] ripple_add(input logic [BLK-1:0] a,
                                               input logic [BLK-1:0] b,
                                               input logic           c);
    logic [BLK:0] s;
    logic         cy;
    cy = c;
    s  = '0;
    for (int i = 0; i < int'(BLK); i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    s[BLK] = cy;
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand prep
  // ---------------------------------------------------------------------------
  logic             w_advance;
  logic [WIDTH-1:0] w_bp;
  logic             w_c0;

  assign w_bp = in_sub ? ~in_b : in_b;
  assign w_c0 = in_sub | in_cin;

  // ---------------------------------------------------------------------------
  // Stage state
  // r_a / r_b[k]: the operands not yet consumed, already shifted down so that
  //               the next block sits in bits [BLK-1:0]. They feed stage k+1.
  // r_sum[k]:     finished sum blocks. Each new block enters at the top while
  //               older blocks shift down. After the last stage the result is
  //               therefore aligned.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_a   [NOPR];
  logic [WIDTH-1:0] r_b   [NOPR];
  logic [WIDTH-1:0] r_sum [NBLK];
  logic             r_c   [NBLK];
  logic [NBLK-1:0]  r_v;

  // Per-stage inputs and carry-select results
  logic [WIDTH-1:0] w_a      [NBLK];
  logic [WIDTH-1:0] w_b      [NBLK];
  logic [WIDTH-1:0] w_sum_in [NBLK];
  logic             w_cin    [NBLK];
  logic [NBLK-1:0]  w_vin;
  logic [BLK:0]     w_s0     [NBLK];
  logic [BLK:0]     w_s1     [NBLK];
  logic [BLK:0]     w_sel    [NBLK];

  for (genvar k = 0; k < int'(NBLK); k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_a[k]      = in_a;
      assign w_b[k]      = w_bp;
      assign w_cin[k]    = w_c0;
      assign w_sum_in[k] = '0;
      assign w_vin[k]    = in_valid;
    end else begin : g_body
      assign w_a[k]      = r_a[k-1];
      assign w_b[k]      = r_b[k-1];
      assign w_cin[k]    = r_c[k-1];
      assign w_sum_in[k] = r_sum[k-1];
      assign w_vin[k]    = r_v[k-1];
    end

    // Both carry assumptions are computed up front. The registered carry
    // from the stage below only drives the mux.
    assign w_s0[k]  = ripple_add(w_a[k][BLK-1:0], w_b[k][BLK-1:0], 1'b0);
    assign w_s1[k]  = ripple_add(w_a[k][BLK-1:0], w_b[k][BLK-1:0], 1'b1);
    assign w_sel[k] = w_cin[k] ? w_s1[k] : w_s0[k];
  end

  assign w_advance = out_ready | ~r_v[NBLK-1];
  assign in_ready  = w_advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int k = 0; k < int'(NBLK); k++) begin
        r_c[k]   <= 1'b0;
        r_sum[k] <= '0;
      end
      for (int k = 0; k < int'(NBLK) - 1; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
    end else if (w_advance) begin
      for (int k = 0; k < int'(NBLK); k++) begin
        r_v[k]   <= w_vin[k];
        r_c[k]   <= w_sel[k][BLK];
        r_sum[k] <= (WIDTH'(w_sel[k][BLK-1:0]) << (WIDTH - BLK)) | (w_sum_in[k] >> BLK);
      end
      for (int k = 0; k < int'(NBLK) - 1; k++) begin
        r_a[k] <= w_a[k] >> BLK;
        r_b[k] <= w_b[k] >> BLK;
      end
    end
  end

  assign out_valid = r_v[NBLK-1];
  assign out_sum   = r_sum[NBLK-1];
  assign out_cout  = r_c[NBLK-1];

`ifdef CSEL_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit of the last block:
  // s = a ^ b ^ c_in, so c_in = a ^ b ^ s.
  logic w_msb_cin;
  logic r_ovf;

  assign w_msb_cin = w_a[NBLK-1][BLK-1] ^ w_b[NBLK-1][BLK-1] ^ w_sel[NBLK-1][BLK-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_advance) begin
      r_ovf <= w_msb_cin ^ w_sel[NBLK-1][BLK];
    end
  end

  assign out_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_csel_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_csel_pipe_adder
//
// Three instances share one stimulus: BLK=16 (latency 4), BLK=8 (latency 8)
// and BLK=64 (latency 1). Most checks target the BLK=16 instance. Latency is
// checked on all three.
// -----------------------------------------------------------------------------
module tb_csel_pipe_adder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_cin;
  logic        in_sub;
  logic        out_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;

  logic        rdy16, vld16, cout16;
  logic        rdy8,  vld8,  cout8;
  logic        rdy64, vld64, cout64;
  logic [63:0] sum16, sum8, sum64;
`ifdef CSEL_OVF_EN
  logic        ovf16, ovf8, ovf64;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  csel_pipe_adder #(.WIDTH(64), .BLK(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .out_valid(vld16), .out_ready(out_ready),
    .out_sum(sum16), .out_cout(cout16)
`ifdef CSEL_OVF_EN
    , .out_ovf(ovf16)
`endif
  );

  csel_pipe_adder #(.WIDTH(64), .BLK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .out_valid(vld8), .out_ready(out_ready),
    .out_sum(sum8), .out_cout(cout8)
`ifdef CSEL_OVF_EN
    , .out_ovf(ovf8)
`endif
  );

  csel_pipe_adder #(.WIDTH(64), .BLK(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .out_valid(vld64), .out_ready(out_ready),
    .out_sum(sum64), .out_cout(cout64)
`ifdef CSEL_OVF_EN
    , .out_ovf(ovf64)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, cout, sum}
  function automatic logic [65:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
    logic [63:0] bp;
    logic [64:0] s;
    logic        cmsb;
    bp   = sub ? ~b : b;
    s    = {1'b0, a} + {1'b0, bp} + 65'(sub ? 1'b1 : cin);
    cmsb = a[63] ^ bp[63] ^ s[63];
    return {cmsb ^ s[64], s};
  endfunction

  // Directed vectors with hand-computed results
  logic [63:0] va   [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h5, 64'h7, 64'h7FFF_FFFF_FFFF_FFFF,
                            64'h0000_0000_0000_FFFF, 64'h8000_0000_0000_0000};
  logic [63:0] vb   [6] = '{64'h1, 64'h7, 64'h5, 64'h1, 64'h0, 64'h1};
  logic        vcin [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        vsub [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [63:0] vsum [6] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h2, 64'h8000_0000_0000_0000,
                            64'h0000_0000_0001_0000, 64'h7FFF_FFFF_FFFF_FFFF};
  logic        vco  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        vovf [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // One operation into an empty pipeline. out_valid must pulse exactly at
  // edge 1 / 4 / 8, counting the accept edge as 1.
  task automatic run_vec(input int idx);
    in_a      = va[idx];
    in_b      = vb[idx];
    in_cin    = vcin[idx];
    in_sub    = vsub[idx];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check($sformatf("vec%0d_in_ready", idx), rdy16, 1'b1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid16_e%0d", idx, e), vld16, e == 4);
      check($sformatf("vec%0d_valid8_e%0d", idx, e), vld8, e == 8);
      check($sformatf("vec%0d_valid64_e%0d", idx, e), vld64, e == 1);
      if (e == 4) begin
        check($sformatf("vec%0d_sum16", idx), sum16, vsum[idx]);
        check($sformatf("vec%0d_cout16", idx), cout16, vco[idx]);
`ifdef CSEL_OVF_EN
        check($sformatf("vec%0d_ovf16", idx), ovf16, vovf[idx]);
`endif
      end
      if (e == 8) begin
        check($sformatf("vec%0d_sum8", idx), sum8, vsum[idx]);
        check($sformatf("vec%0d_cout8", idx), cout8, vco[idx]);
      end
      if (e == 1) begin
        check($sformatf("vec%0d_sum64", idx), sum64, vsum[idx]);
        check($sformatf("vec%0d_cout64", idx), cout64, vco[idx]);
`ifdef CSEL_OVF_EN
        check($sformatf("vec%0d_ovf64", idx), ovf64, vovf[idx]);
`endif
      end
    end
  endtask

  logic [65:0] q[$];
  logic [65:0] exp_r;
  int          wait_cnt;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid16", vld16, 1'b0);
    check("rst_sum16", sum16, 64'h0);
    check("rst_cout16", cout16, 1'b0);
    check("rst_in_ready16", rdy16, 1'b1);
    check("rst_valid8", vld8, 1'b0);
    check("rst_valid64", vld64, 1'b0);

    // Directed arithmetic and latency
    for (int i = 0; i < 6; i++) run_vec(i);

    // Back-to-back: 8 accepts A=i, B=3i, so the sum is 4i
    out_ready = 1'b1;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    for (int t = 0; t <= 15; t++) begin
      in_valid = (t < 8);
      in_a     = 64'(t);
      in_b     = 64'(3 * t);
      #1;
      if (t < 8) check($sformatf("b2b_in_ready_t%0d", t), rdy16, 1'b1);
      tick();
      check($sformatf("b2b_valid16_t%0d", t), vld16, (t >= 3) && (t <= 10));
      if (t >= 3 && t <= 10) check($sformatf("b2b_sum16_t%0d", t), sum16, 64'(4 * (t - 3)));
      check($sformatf("b2b_valid8_t%0d", t), vld8, (t >= 7) && (t <= 14));
      if (t >= 7 && t <= 14) check($sformatf("b2b_sum8_t%0d", t), sum8, 64'(4 * (t - 7)));
      check($sformatf("b2b_valid64_t%0d", t), vld64, t <= 7);
      if (t <= 7) check($sformatf("b2b_sum64_t%0d", t), sum64, 64'(4 * t));
    end
    in_valid = 1'b0;

    // Backpressure: 4 ops with sums 100+2i, then stall 3 cycles on the first
    for (int t = 0; t < 4; t++) begin
      in_valid = 1'b1;
      in_a     = 64'(100 + t);
      in_b     = 64'(t);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      check($sformatf("bp_valid_s%0d", s), vld16, 1'b1);
      check($sformatf("bp_sum_s%0d", s), sum16, 64'd100);
      check($sformatf("bp_in_ready_s%0d", s), rdy16, 1'b0);
      tick();
    end
    check("bp_sum_held", sum16, 64'd100);
    out_ready = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      tick();
      check($sformatf("bp_rel_valid_r%0d", r), vld16, r <= 3);
      if (r <= 3) check($sformatf("bp_rel_sum_r%0d", r), sum16, 64'(100 + 2 * r));
    end

    // Reset mid-flight: 3 ops in the pipeline, then a one-cycle reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1;
      in_a     = 64'(t + 1);
      in_b     = 64'(t + 1);
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid16", vld16, 1'b0);
    check("mid_rst_sum16", sum16, 64'h0);
    check("mid_rst_cout16", cout16, 1'b0);
    for (int t = 0; t < 10; t++) begin
      tick();
      check($sformatf("mid_rst_quiet16_t%0d", t), vld16, 1'b0);
      check($sformatf("mid_rst_quiet8_t%0d", t), vld8, 1'b0);
      check($sformatf("mid_rst_quiet64_t%0d", t), vld64, 1'b0);
    end
    run_vec(2);

    // Random traffic with random backpressure against the reference model
    q.delete();
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = {$urandom, $urandom};
      in_b      = {$urandom, $urandom};
      in_cin    = 1'($urandom_range(0, 1));
      in_sub    = 1'($urandom_range(0, 1));
      #1;
      if (vld16 && out_ready) begin
        check("rnd_expected_pending", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          exp_r = q.pop_front();
          check("rnd_sum", sum16, exp_r[63:0]);
          check("rnd_cout", cout16, exp_r[64]);
`ifdef CSEL_OVF_EN
          check("rnd_ovf", ovf16, exp_r[65]);
`endif
        end
      end
      if (in_valid && rdy16) q.push_back(ref_add(in_a, in_b, in_cin, in_sub));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_cnt  = 0;
    while (q.size() != 0 && wait_cnt < 40) begin
      #1;
      if (vld16) begin
        exp_r = q.pop_front();
        check("drain_sum", sum16, exp_r[63:0]);
        check("drain_cout", cout16, exp_r[64]);
      end
      tick();
      wait_cnt++;
    end
    check("drain_queue_empty", 32'(q.size()), 32'd0);
    check("drain_no_extra_valid", vld16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
